// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: decodes the ID opcode into a 10-bit control bundle, carries it through EX/MEM/WB,
// and generates load-use stalls, mult/div holds, branch flushes and the illegal-opcode flag.
module pipelined_control_unit #(
    parameter int OP_W       = 5,
    parameter int REG_W      = 5,
    parameter int MD_LATENCY = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_id_valid,
    input  logic [OP_W-1:0]  i_id_opcode,
    input  logic [4:0]       i_id_aluop,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic [REG_W-1:0] i_id_rd,
    input  logic             i_ex_branch_taken,
    output logic [9:0]       o_ex_ctrl,
    output logic [9:0]       o_mem_ctrl,
    output logic [9:0]       o_wb_ctrl,
    output logic [REG_W-1:0] o_ex_rd,
    output logic [REG_W-1:0] o_wb_rd,
    output logic             o_stall,
    output logic             o_flush_ifid,
    output logic             o_illegal_op
);
    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] MD_INIT = CW'(MD_LATENCY - 1);
    localparam logic [REG_W-1:0] LINK = '1;
    localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(8);

    logic [9:0]       r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
    logic [REG_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic [CW-1:0]    r_md_count;
    logic [9:0]       w_dec;
    logic [REG_W-1:0] w_dest;
    logic             w_known, w_reads_rt, w_is_md, w_md_busy, w_load_use, w_bubble;

    always_comb begin
        w_dec      = '0;
        w_known    = 1'b1;
        w_reads_rt = 1'b0;
        w_dest     = i_id_rd;
        case (i_id_opcode)
            OP_R: begin
                w_dec      = 10'h006;
                w_reads_rt = 1'b1;
            end
            OP_ADDI: w_dec = 10'h024;
            OP_LW:   w_dec = 10'h025;
            OP_SW: begin
                w_dec      = 10'h028;
                w_reads_rt = 1'b1;
            end
            OP_J:    w_dec = 10'h040;
            OP_JAL: begin
                w_dec  = 10'h244;
                w_dest = LINK;
            end
            OP_JR:   w_dec = 10'h100;
            OP_BNE, OP_BLT: begin
                w_dec      = 10'h090;
                w_reads_rt = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
        if (w_dest == '0) w_dec[2] = 1'b0;
    end

    assign w_is_md    = (i_id_opcode == OP_R) & ((i_id_aluop == 5'b00110) | (i_id_aluop == 5'b00111));
    assign w_md_busy  = r_md_count != '0;
    assign w_load_use = r_ex_ctrl[0] & (r_ex_rd != '0) & i_id_valid &
                        ((r_ex_rd == i_id_rs) | (w_reads_rt & (r_ex_rd == i_id_rt)));
    assign w_bubble   = i_ex_branch_taken | w_load_use | ~i_id_valid;

    // Gated by reset so both drop the moment reset rises, before any state clears.
    assign o_stall      = ~i_reset & (w_md_busy | (w_load_use & ~i_ex_branch_taken));
    assign o_flush_ifid = ~i_reset & i_ex_branch_taken & ~w_md_busy;
    assign o_illegal_op = i_id_valid & ~w_known;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ex_ctrl  <= '0;
            r_mem_ctrl <= '0;
            r_wb_ctrl  <= '0;
            r_ex_rd    <= '0;
            r_mem_rd   <= '0;
            r_wb_rd    <= '0;
            r_md_count <= '0;
        end else begin
            r_mem_ctrl <= w_md_busy ? '0 : r_ex_ctrl;
            r_mem_rd   <= w_md_busy ? '0 : r_ex_rd;
            r_wb_ctrl  <= r_mem_ctrl;
            r_wb_rd    <= r_mem_rd;
            if (w_md_busy) begin
                r_md_count <= r_md_count - CW'(1);
            end else if (w_bubble) begin
                r_ex_ctrl <= '0;
                r_ex_rd   <= '0;
            end else begin
                r_ex_ctrl <= w_dec;
                r_ex_rd   <= w_dest;
                if (w_is_md) r_md_count <= MD_INIT;
            end
        end
    end

    assign o_ex_ctrl  = r_ex_ctrl;
    assign o_mem_ctrl = r_mem_ctrl;
    assign o_wb_ctrl  = r_wb_ctrl;
    assign o_ex_rd    = r_ex_rd;
    assign o_wb_rd    = r_wb_rd;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed and randomized checks of the control unit against an
// instruction-level reference model of decode, hazards and mult/div occupancy.
module tb_pipelined_control_unit;
    localparam int ML = 4;
    localparam logic [9:0] JAL = 10'h200, JR = 10'h100, BR = 10'h080, JP = 10'h040, ALUINB = 10'h020,
                           ALUSUB = 10'h010, DMWE = 10'h008, RWE = 10'h004, RDST = 10'h002, RWD = 10'h001;

    logic       clk = 1'b0, rst;
    logic       id_valid, bt;
    logic [4:0] opcode, aluop, rs, rt, rd;
    logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0] ex_rd, wb_rd;
    logic       stall, flush, illegal;

    int vectors = 0, miscompares = 0;

    logic [9:0] m_ex, m_mem, m_wb;
    logic [4:0] m_ex_rd, m_mem_rd, m_wb_rd;
    logic       m_ex_load;
    int         m_hold;

    pipelined_control_unit #(.OP_W(5), .REG_W(5), .MD_LATENCY(ML)) dut (
        .i_clock(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_opcode(opcode), .i_id_aluop(aluop),
        .i_id_rs(rs), .i_id_rt(rt), .i_id_rd(rd), .i_ex_branch_taken(bt),
        .o_ex_ctrl(ex_ctrl), .o_mem_ctrl(mem_ctrl), .o_wb_ctrl(wb_ctrl), .o_ex_rd(ex_rd), .o_wb_rd(wb_rd),
        .o_stall(stall), .o_flush_ifid(flush), .o_illegal_op(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic known(input logic [4:0] op);
        return op <= 5'd8;
    endfunction

    function automatic logic reads_rt(input logic [4:0] op);
        return op == 5'd0 || op == 5'd7 || op == 5'd2 || op == 5'd6;
    endfunction

    function automatic logic [4:0] dest(input logic [4:0] op, input logic [4:0] d);
        return (op == 5'd3) ? 5'd31 : d;
    endfunction

    function automatic logic [9:0] bundle(input logic [4:0] op, input logic [4:0] d);
        logic [9:0] b;
        case (op)
            5'd0:       b = RWE | RDST;
            5'd5:       b = ALUINB | RWE;
            5'd8:       b = ALUINB | RWE | RWD;
            5'd7:       b = ALUINB | DMWE;
            5'd1:       b = JP;
            5'd3:       b = JP | JAL | RWE;
            5'd4:       b = JR;
            5'd2, 5'd6: b = BR | ALUSUB;
            default:    b = 10'h000;
        endcase
        return (dest(op, d) == 5'd0) ? (b & ~RWE) : b;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0;
        m_ex_rd = '0; m_mem_rd = '0; m_wb_rd = '0;
        m_ex_load = 1'b0; m_hold = 0;
    endtask

    // One instruction slot: drive ID, check every output against the model, then clock and advance the model.
    task automatic step(input logic v, input logic [4:0] op, input logic [4:0] alu, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic b);
        logic busy, lu;
        id_valid = v; opcode = op; aluop = alu; rs = s; rt = t; rd = d; bt = b;
        #1;
        busy = m_hold > 0;
        lu = m_ex_load && m_ex_rd != 0 && v && (m_ex_rd == s || (reads_rt(op) && m_ex_rd == t));
        chk("ex_ctrl", ex_ctrl, m_ex);
        chk("mem_ctrl", mem_ctrl, m_mem);
        chk("wb_ctrl", wb_ctrl, m_wb);
        chk("ex_rd", 10'(ex_rd), 10'(m_ex_rd));
        chk("wb_rd", 10'(wb_rd), 10'(m_wb_rd));
        chk("stall", 10'(stall), 10'(busy || (lu && !b)));
        chk("flush_ifid", 10'(flush), 10'(b && !busy));
        chk("illegal_op", 10'(illegal), 10'(v && !known(op)));
        @(posedge clk);
        m_wb = m_mem; m_wb_rd = m_mem_rd;
        m_mem = busy ? '0 : m_ex; m_mem_rd = busy ? '0 : m_ex_rd;
        if (busy) m_hold--;
        else if (b || lu || !v) begin
            m_ex = '0; m_ex_rd = '0; m_ex_load = 1'b0;
        end else begin
            m_ex = bundle(op, d); m_ex_rd = dest(op, d); m_ex_load = (op == 5'd8);
            m_hold = (op == 5'd0 && (alu == 5'd6 || alu == 5'd7)) ? ML - 1 : 0;
        end
        #1;
    endtask

    initial begin
        logic [4:0] ops [11] = '{5'd0, 5'd5, 5'd8, 5'd7, 5'd1, 5'd3, 5'd4, 5'd2, 5'd6, 5'd31, 5'd9};
        int stalls;
        rst = 1'b1; id_valid = 1'b0; opcode = '0; aluop = '0; rs = '0; rt = '0; rd = '0; bt = 1'b1;
        model_reset();
        #12;
        chk("reset_ex_ctrl", ex_ctrl, 10'h000);
        chk("reset_wb_ctrl", wb_ctrl, 10'h000);
        chk("reset_flush", 10'(flush), 10'h000);
        bt = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        // addi r3 then sw: no hazard, addi reaches WB after three edges
        step(1, 5'd5, 0, 5'd1, 5'd0, 5'd3, 0);
        chk("addi_ex", ex_ctrl, 10'h024);
        step(1, 5'd7, 0, 5'd3, 5'd3, 5'd0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("addi_wb", wb_ctrl, 10'h024);
        chk("addi_wb_rd", 10'(wb_rd), 10'd3);
        // lw r5 then add r6,r5,r1: one bubble then the R-type
        step(1, 5'd8, 0, 5'd2, 5'd0, 5'd5, 0);
        step(1, 5'd0, 0, 5'd5, 5'd1, 5'd6, 0);
        chk("lu_bubble", ex_ctrl, 10'h000);
        step(1, 5'd0, 0, 5'd5, 5'd1, 5'd6, 0);
        chk("lu_rtype", ex_ctrl, 10'h006);
        // mult holds EX for ML cycles
        step(1, 5'd0, 5'd6, 5'd1, 5'd2, 5'd7, 0);
        stalls = 0;
        for (int i = 0; i < ML; i++) begin
            #0 stalls += 0;
            id_valid = 1'b1; opcode = 5'd5; rs = 5'd1; rd = 5'd4; bt = 1'b0; #1;
            stalls += int'(stall);
            #0 step(1, 5'd5, 0, 5'd1, 5'd0, 5'd4, 0);
        end
        chk("md_stall_cycles", 10'(stalls), 10'(ML - 1));
        chk("md_next_issue", ex_ctrl, 10'h024);
        // branch taken while ID has a load-use hazard: flush wins
        step(1, 5'd8, 0, 5'd1, 5'd0, 5'd2, 0);
        step(1, 5'd0, 0, 5'd2, 5'd3, 5'd4, 1);
        chk("br_bubble", ex_ctrl, 10'h000);
        // illegal opcode and addi to r0
        step(1, 5'd31, 0, 5'd1, 5'd1, 5'd1, 0);
        chk("illegal_bundle", ex_ctrl, 10'h000);
        step(1, 5'd5, 0, 5'd1, 5'd0, 5'd0, 0);
        chk("addi_r0", ex_ctrl, 10'h020);
        step(1, 5'd3, 0, 5'd1, 5'd0, 5'd0, 0);
        chk("jal_link", 10'(ex_rd), 10'd31);
        // reset in the middle of a mult
        step(1, 5'd0, 5'd7, 5'd1, 5'd2, 5'd9, 0);
        step(1, 5'd0, 0, 5'd1, 5'd2, 5'd3, 0);
        bt = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ex", ex_ctrl, 10'h000);
        chk("mid_rst_mem", mem_ctrl, 10'h000);
        chk("mid_rst_ex_rd", 10'(ex_rd), 10'h000);
        chk("mid_rst_stall", 10'(stall), 10'h000);
        chk("mid_rst_flush", 10'(flush), 10'h000);
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        step(1, 5'd8, 0, 5'd1, 5'd0, 5'd1, 0);
        chk("post_rst_decode", ex_ctrl, 10'h025);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) != 0, ops[$urandom_range(0, 10)], 5'($urandom_range(4, 7)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 4) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
